// File: rtl/mult_arbiter_seq.sv
// mult_arbiter_seq: round-robin arbiter and sequencer sharing one shift-add multiplier datapath between two ports
module mult_arbiter_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   op_a0,
  input  logic [WIDTH-1:0]   op_b0,
  input  logic [WIDTH-1:0]   op_a1,
  input  logic [WIDTH-1:0]   op_b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [WIDTH-1:0]   dp_a,
  output logic [WIDTH-1:0]   dp_b,
  output logic               dp_init,
  output logic               dp_add,
  output logic               dp_shift,
  input  logic               dp_lsb,
  input  logic [2*WIDTH-1:0] dp_product,
  output logic [2*WIDTH-1:0] res,
  output logic               done0,
  output logic               done1
);
  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic owner, last, pick, grant;
  always_comb begin
    pick = (req0 && req1) ? ~last : req1;
    grant = (state == IDLE) && (req0 || req1);
    gnt0 = grant && !pick;
    gnt1 = grant && pick;
    dp_init = state == LOAD;
    dp_add = state == ADD;
    dp_shift = state == SHIFT;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? LOAD : IDLE;
      LOAD:    state_nx = TEST;
      TEST:    state_nx = dp_lsb ? ADD : SHIFT;
      ADD:     state_nx = SHIFT;
      SHIFT:   state_nx = (cnt == CNT_W'(1)) ? DONE : TEST;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_a <= '0;
      dp_b <= '0;
      res <= '0;
      cnt <= '0;
      owner <= 1'b0;
      last <= 1'b1;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      done0 <= (state == DONE) && !owner;
      done1 <= (state == DONE) && owner;
      if (grant) begin
        dp_a <= pick ? op_a1 : op_a0;
        dp_b <= pick ? op_b1 : op_b0;
        owner <= pick;
        last <= pick;
      end
      if (state == LOAD) cnt <= CNT_W'(WIDTH);
      if (state == SHIFT) cnt <= cnt - CNT_W'(1);
      if (state == DONE) res <= dp_product;
    end
  end
endmodule

// File: tb/tb_mult_arbiter_seq.sv
// tb_mult_arbiter_seq: self-checking bench with a transaction-level model and a shift-add datapath model
module tb_mult_arbiter_seq;
  localparam int WIDTH = 8;
  logic clk = 0, reset = 1, req0 = 0, req1 = 0, dp_lsb;
  logic [WIDTH-1:0] op_a0 = 0, op_b0 = 0, op_a1 = 0, op_b1 = 0, dp_a, dp_b;
  logic gnt0, gnt1, dp_init, dp_add, dp_shift, done0, done1;
  logic [2*WIDTH-1:0] dp_product, res;
  logic [2*WIDTH:0] acc = '0;
  int n_pass = 0, n_chk = 0;
  logic g0_seen = 0, g1_seen = 0;

  mult_arbiter_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .gnt0(gnt0), .gnt1(gnt1), .dp_a(dp_a), .dp_b(dp_b),
    .dp_init(dp_init), .dp_add(dp_add), .dp_shift(dp_shift),
    .dp_lsb(dp_lsb), .dp_product(dp_product), .res(res),
    .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  assign dp_lsb = acc[0];
  assign dp_product = acc[2*WIDTH-1:0];
  always @(posedge clk) begin
    if (dp_init) acc <= {{(WIDTH+1){1'b0}}, dp_b};
    else if (dp_add) acc <= {{1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dp_a}, acc[WIDTH-1:0]};
    else if (dp_shift) acc <= acc >> 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  int cyc = 0, m_done_at = 0, m_init_at = -1, n_add = 0, n_sh = 0;
  logic m_busy = 0, m_last = 1, m_owner = 0;
  logic [2*WIDTH-1:0] m_res = 0, m_job = 0;
  logic [WIDTH-1:0] m_a = 0, m_b = 0;
  always @(negedge clk) begin
    logic e_g0, e_g1, e_d0, e_d1, pk, act;
    g0_seen = gnt0;
    g1_seen = gnt1;
    if (reset) begin
      m_busy = 0; m_last = 1; m_res = 0; m_a = 0; m_b = 0; m_init_at = -1;
    end else begin
      e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0;
      act = m_busy && (cyc < m_done_at - 1);
      if (m_busy && cyc == m_done_at) begin
        m_busy = 0;
        m_res = m_job;
        if (m_owner) e_d1 = 1; else e_d0 = 1;
        chk("add_count", n_add, $countones(m_b));
        chk("shift_count", n_sh, WIDTH);
      end
      chk("dp_a", int'(dp_a), int'(m_a));
      chk("dp_b", int'(dp_b), int'(m_b));
      if (!m_busy && (req0 || req1)) begin
        pk = (req0 && req1) ? !m_last : req1;
        e_g0 = !pk; e_g1 = pk;
        m_busy = 1; m_owner = pk; m_last = pk;
        m_a = pk ? op_a1 : op_a0;
        m_b = pk ? op_b1 : op_b0;
        m_job = {{WIDTH{1'b0}}, m_a} * {{WIDTH{1'b0}}, m_b};
        m_done_at = cyc + 2 * WIDTH + 3 + $countones(m_b);
        m_init_at = cyc + 1;
        n_add = 0; n_sh = 0;
      end
      chk("gnt0", int'(gnt0), int'(e_g0));
      chk("gnt1", int'(gnt1), int'(e_g1));
      chk("done0", int'(done0), int'(e_d0));
      chk("done1", int'(done1), int'(e_d1));
      chk("res", int'(res), int'(m_res));
      chk("dp_init", int'(dp_init), int'(cyc == m_init_at));
      if (act) chk("strobe_onehot", int'($countones({dp_init, dp_add, dp_shift}) <= 1), 1);
      else chk("idle_strobes", int'({dp_init, dp_add, dp_shift}), 0);
      n_add += int'(dp_add);
      n_sh += int'(dp_shift);
    end
    cyc++;
  end

  task automatic raise(input int p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (p == 1) begin req1 = 1; op_a1 = a; op_b1 = b; end
    else begin req0 = 1; op_a0 = a; op_b0 = b; end
  endtask

  task automatic wait_gnt(input int p);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 1) ? gnt1 : gnt0;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(input int p, output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("init_c1", int'(dp_init), 1);
      ok = (p == 1) ? done1 : done0;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic job(input int p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input int lat, input int exp);
    int n;
    @(posedge clk); #1;
    raise(p, a, b);
    wait_gnt(p);
    @(posedge clk); #1;
    if (p == 1) req1 = 0; else req0 = 0;
    wait_done(p, n);
    chk("latency", n, lat);
    chk("product", int'(res), exp);
  endtask

  initial begin
    int n, g1cnt;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_res", int'(res), 0);
    chk("rst_dp_a", int'(dp_a), 0);
    chk("rst_strobes", int'({dp_init, dp_add, dp_shift, done0, done1, gnt0, gnt1}), 0);
    job(0, 8'd13, 8'd11, 22, 143);
    job(1, 8'd200, 8'd0, 19, 0);
    @(posedge clk); #1;
    raise(0, 8'd3, 8'd5);
    raise(1, 8'd7, 8'd9);
    @(negedge clk);
    chk("tie_gnt0", int'(gnt0), 1);
    chk("tie_gnt1", int'(gnt1), 0);
    @(posedge clk); #1 req0 = 0;
    wait_done(0, n);
    chk("tie_lat0", n, 21);
    chk("tie_res0", int'(res), 15);
    chk("tie_gnt1_in_done", int'(gnt1), 1);
    @(posedge clk); #1 req1 = 0;
    wait_done(1, n);
    chk("tie_res1", int'(res), 63);
    @(posedge clk); #1;
    raise(0, 8'd2, 8'd2);
    raise(1, 8'd4, 8'd4);
    @(negedge clk);
    chk("alt_gnt0", int'(gnt0), 1);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    wait_done(0, n);
    chk("alt_res", int'(res), 4);
    job(0, 8'd255, 8'd255, 27, 65025);
    @(posedge clk); #1;
    raise(0, 8'd255, 8'd255);
    wait_gnt(0);
    @(posedge clk); #1 req0 = 0;
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midrst_strobes", int'({dp_init, dp_add, dp_shift}), 0);
    chk("midrst_res", int'(res), 0);
    chk("midrst_done", int'({done0, done1}), 0);
    repeat (30) @(negedge clk);
    job(0, 8'd6, 8'd7, 22, 42);
    @(posedge clk); #1;
    raise(0, 8'd9, 8'd3);
    wait_gnt(0);
    @(posedge clk); #1 req0 = 0;
    repeat (4) @(posedge clk);
    #1 raise(1, 8'd1, 8'd1);
    repeat (5) @(posedge clk);
    #1 req1 = 0;
    g1cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      g1cnt += int'(gnt1);
    end
    chk("withdrawn_gnt1", g1cnt, 0);
    chk("withdrawn_res", int'(res), 27);
    repeat (3000) begin
      @(posedge clk); #1;
      if (g0_seen) req0 = 0;
      else if (req0 && $urandom_range(0, 19) == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) raise(0, WIDTH'($urandom), WIDTH'($urandom));
      if (g1_seen) req1 = 0;
      else if (req1 && $urandom_range(0, 19) == 0) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) raise(1, WIDTH'($urandom), WIDTH'($urandom));
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_arbiter_seq.md
Name: mult_arbiter_seq

Overview:
- Shares one external shift-add multiplier datapath between two requesters (port 0, port 1).
- Round-robin arbitration over a req/gnt handshake; the granted operand pair is captured and driven to the datapath.
- Sequences the datapath through init/test/add/shift iterations using an internal iteration counter.
- Returns the 2*WIDTH-bit product with a per-port done pulse.

Parameters:
- WIDTH, 8, operand width and number of shift iterations.
- CNT_W, 4, iteration counter width; must represent WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  request, held high until the matching gnt.
- op_a0, op_b0  in  WIDTH  port-0 multiplicand and multiplier.
- op_a1, op_b1  in  WIDTH  port-1 multiplicand and multiplier.
- gnt0, gnt1  out  1  one-cycle grant; operands are sampled on this edge.
- dp_a, dp_b  out  WIDTH  registered operands driven to the datapath.
- dp_init  out  1  datapath clears the product and loads dp_a/dp_b.
- dp_add  out  1  datapath adds the multiplicand into the product high half.
- dp_shift  out  1  datapath shifts the product/multiplier right by 1.
- dp_lsb  in  1  current multiplier LSB from the datapath.
- dp_product  in  2*WIDTH  datapath product.
- res  out  2*WIDTH  last completed product.
- done0, done1  out  1  one-cycle completion pulse per port.

Behaviour:
- Reset:
  - state=IDLE; dp_a, dp_b, res = 0.
  - gnt*, done*, dp_* strobes = 0.
  - RR pointer last=1, so port 0 wins the first tie.
  - Reset mid-operation abandons the job: no done pulse, res unchanged at 0.
- States are IDLE, LOAD, TEST, ADD, SHIFT, DONE. Exactly one of dp_init/dp_add/dp_shift is high per cycle, or none.
- IDLE:
  - Single requester: that port is granted.
  - Both requesting: the port != last is granted.
  - gnt is combinational (IDLE & chosen req) and lasts exactly one cycle.
  - On that edge: dp_a/dp_b <= granted operands, owner <= id, last <= id, state -> LOAD.
  - No requests: remain in IDLE.
- LOAD: dp_init=1; cnt <= WIDTH; -> TEST.
- TEST (no strobe): dp_lsb=1 -> ADD; otherwise -> SHIFT.
- ADD: dp_add=1; -> SHIFT.
- SHIFT: dp_shift=1; cnt <= cnt-1; cnt==1 -> DONE; otherwise -> TEST.
- DONE: res <= dp_product; -> IDLE.
  - The registered done<owner> pulse is high the cycle after DONE, coincident with the new res.
  - A new grant may occur in that same cycle.
- Latency: gnt cycle = C0; done pulse at C(2*WIDTH+3+popcount(B)).
- Requests raised while not in IDLE are not granted until IDLE; gnt never fires outside IDLE.
- Deasserting req before gnt withdraws the request; no error.
- dp_a/dp_b hold stable from LOAD until the next grant.
- res holds its value between completions.

Test Plan:
- Reset, then req0=1, A=13, B=11 (WIDTH=8) -> gnt0 at C0; dp_init at C1; 3 dp_add and 8 dp_shift strobes; done0 at C22; res=143; done1 never asserts.
- req1 only, A=200, B=0 -> gnt1 at C0; no dp_add; done1 at C19; res=0.
- req0 and req1 asserted together after reset and held -> gnt0 first, done0, then gnt1 in the done0 cycle, then done1; next grant alternates back to port 0.
- A=255, B=255 -> 8 adds, done at C27, res=65025.
- Reset asserted at C10 of an active job -> next cycle state IDLE, all strobes 0, res=0, no done pulse; a following req0 is served normally.
- req1 raised mid-job of port 0 and dropped before DONE -> gnt1 never asserts; after DONE, state IDLE with no grant.
